branch_history_table: RTL and testbench

//  Dynamic branch predictor that drives the 1-bit `jump` input of the PC selector.
//  - Holds 2^INDEX_BITS 2-bit saturating counters, indexed by PC.
//  - Predicts taken/not-taken for the branch in FD combinationally.
//  - Trains on resolved outcomes from the X-stage branch checker.
//  - Keeps branch and mispredict performance counters.

---
 rtl/branch_history_table.sv | 91 +++++++++
 tb/tb_branch_history_table.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Purpose: 2-bit saturating-counter branch predictor with training and performance counters.
// Latency: the prediction is combinational (0 cycles); training, mispredict and counters update at the next clk.
// Backpressure: none. stall only masks the prediction; training continues whenever update_valid is high.
module branch_history_table #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CTR_INIT   = 2'b01,
    parameter int         PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bp_enable,
    input  logic                  stall,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  jump,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  mispredict,
    input  logic                  perf_clear,
    output logic [PERF_WIDTH-1:0] branch_count,
    output logic [PERF_WIDTH-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            ctr_table [ENTRIES];
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_next;
    logic [1:0]            ctr_eff;
    logic                  update_miss;
    logic                  unused_pc_bits;

    // Word-aligned PCs: the byte offset and the high bits do not select an entry, so aliasing is allowed.
    assign lookup_idx     = lookup_pc[INDEX_BITS+1:2];
    assign update_idx     = update_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[31:INDEX_BITS+2], update_pc[1:0]};
    assign update_miss    = update_valid & (update_taken != update_predicted);

    // Saturating next value for the entry being trained.
    always_comb begin
        ctr_cur  = ctr_table[update_idx];
        ctr_next = ctr_cur;
        if (update_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Prediction, bypassing the same-cycle update so the lookup sees the newest counter.
    always_comb begin
        ctr_eff = ctr_table[lookup_idx];
        if (update_valid && (update_idx == lookup_idx)) ctr_eff = ctr_next;
        jump = bp_enable & lookup_valid & ~stall & ctr_eff[1];
    end

    // Counter table: reset to CTR_INIT, trained by resolved branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_INIT;
        end else if (update_valid) begin
            ctr_table[update_idx] <= ctr_next;
        end
    end

    // Mispredict flag: reflects only the update resolved in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mispredict <= 1'b0;
        else     mispredict <= update_miss;
    end

    // Performance counters: these wrap naturally, and a clear overrides any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (perf_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid) branch_count     <= branch_count + PERF_WIDTH'(1);
            if (update_miss)  mispredict_count <= mispredict_count + PERF_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Bench for branch_history_table: directed stimulus with a queue-based scoreboard.
// Stimulus queues the expected value together with the cycle it applies to; the monitor compares on the falling edge.
// No flow control: every queued expectation is either consumed on its own cycle or reported as stale.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        bp_enable, stall, lookup_valid, jump;
    logic [31:0] lookup_pc, update_pc;
    logic        update_valid, update_taken, update_predicted;
    logic        mispredict, perf_clear;
    logic [31:0] branch_count, mispredict_count;

    branch_history_table #(.INDEX_BITS(6), .CTR_INIT(2'b01), .PERF_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bp_enable(bp_enable), .stall(stall),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .jump(jump),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_predicted(update_predicted), .mispredict(mispredict), .perf_clear(perf_clear),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: kind 0 jump, 1 mispredict, 2 branch_count, 3 mispredict_count
    int          q_cyc[$];
    int          q_kind[$];
    logic [31:0] q_val[$];
    string       q_name[$];
    int          checks = 0;
    int          errors = 0;

    task automatic expect_val(input int kind, input logic [31:0] val, input string name);
        q_cyc.push_back(cyc);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    // Monitor: pop every expectation that is due this cycle and compare it against the DUT.
    always @(negedge clk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            int          c;
            int          k;
            logic [31:0] v;
            logic [31:0] act;
            string       n;
            c = q_cyc.pop_front();
            k = q_kind.pop_front();
            v = q_val.pop_front();
            n = q_name.pop_front();
            case (k)
                0:       act = {31'd0, jump};
                1:       act = {31'd0, mispredict};
                2:       act = branch_count;
                default: act = mispredict_count;
            endcase
            checks++;
            if (c < cyc) begin
                errors++;
                $display("FAIL %s: stale expectation from cycle %0d (now %0d)", n, c, cyc);
            end else if (act !== v) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", n, act, v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic pred);
        update_valid     = 1'b1;
        update_pc        = pc;
        update_taken     = taken;
        update_predicted = pred;
        step();
        update_valid     = 1'b0;
    endtask

    task automatic look(input logic v, input logic [31:0] pc);
        lookup_valid = v;
        lookup_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; bp_enable = 1'b1; stall = 1'b0; perf_clear = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_predicted = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        look(1'b1, 32'h40);
        expect_val(0, 0, "reset_jump_0x40"); expect_val(1, 0, "reset_mispredict");
        expect_val(2, 0, "reset_branch_count"); expect_val(3, 0, "reset_mispredict_count");
        step();
        look(1'b1, 32'h1234);
        expect_val(0, 0, "reset_jump_0x1234");
        step();

        // 2: train 0x40 to taken, then check its neighbour and an alias
        look(1'b0, 32'h0);
        upd(32'h40, 1'b1, 1'b1);
        upd(32'h40, 1'b1, 1'b1);
        look(1'b1, 32'h40);
        expect_val(0, 1, "trained_0x40"); expect_val(2, 2, "bc_after_2");
        expect_val(3, 0, "mc_after_2"); expect_val(1, 0, "misp_after_correct");
        step();
        look(1'b1, 32'h44);  expect_val(0, 0, "neighbour_0x44"); step();
        look(1'b1, 32'h140); expect_val(0, 1, "alias_0x140");    step();
        look(1'b0, 32'h0);

        // 3: saturation at 0x80
        repeat (5) upd(32'h80, 1'b1, 1'b1);
        upd(32'h80, 1'b0, 1'b1);
        look(1'b1, 32'h80);
        expect_val(0, 1, "sat_st_to_wt"); expect_val(1, 1, "misp_nt_update");
        step();
        look(1'b0, 32'h0);
        upd(32'h80, 1'b0, 1'b1);
        look(1'b1, 32'h80);
        expect_val(0, 0, "sat_wt_to_wnt"); expect_val(2, 9, "bc_after_9"); expect_val(3, 2, "mc_after_9");
        step();
        look(1'b0, 32'h0);

        // 4: same-cycle bypass in both directions (0x40 back to WNT first)
        upd(32'h40, 1'b0, 1'b0);
        upd(32'h40, 1'b0, 1'b0);
        look(1'b1, 32'h40);
        update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_predicted = 1'b0;
        expect_val(0, 1, "bypass_taken");
        step();
        update_valid = 1'b0;
        expect_val(0, 1, "after_bypass_wt"); expect_val(1, 1, "misp_bypass_update");
        step();
        update_valid = 1'b1; update_taken = 1'b0; update_predicted = 1'b1;
        expect_val(0, 0, "bypass_not_taken");
        step();
        update_valid = 1'b0;
        expect_val(0, 0, "after_bypass_wnt");
        step();
        look(1'b0, 32'h0);

        // 5: mispredict flag and perf counters
        perf_clear = 1'b1; step(); perf_clear = 1'b0;
        upd(32'h200, 1'b1, 1'b0);
        expect_val(1, 1, "misp_set"); expect_val(2, 1, "bc_1"); expect_val(3, 1, "mc_1");
        upd(32'h200, 1'b1, 1'b1);
        expect_val(1, 0, "misp_cleared"); expect_val(2, 2, "bc_2"); expect_val(3, 1, "mc_still_1");
        update_valid = 1'b1; update_pc = 32'h200; update_taken = 1'b0; update_predicted = 1'b1;
        perf_clear = 1'b1;
        step();
        update_valid = 1'b0; perf_clear = 1'b0;
        expect_val(2, 0, "clear_wins_bc"); expect_val(3, 0, "clear_wins_mc"); expect_val(1, 1, "misp_with_clear");
        step();
        expect_val(1, 0, "misp_idle_clear");
        step();

        // 6: stall / bp_enable masking, training under stall, mid-run reset
        upd(32'h40, 1'b1, 1'b1);
        upd(32'h40, 1'b1, 1'b1);
        look(1'b1, 32'h40);
        stall = 1'b1; expect_val(0, 0, "stall_masks"); step();
        stall = 1'b0; bp_enable = 1'b0; expect_val(0, 0, "bp_disable_masks"); step();
        bp_enable = 1'b1; expect_val(0, 1, "unmasked_st"); step();
        stall = 1'b1;
        upd(32'h40, 1'b0, 1'b1);
        stall = 1'b0; bp_enable = 1'b0;
        upd(32'h40, 1'b0, 1'b1);
        bp_enable = 1'b1;
        expect_val(0, 0, "trained_while_masked"); step();
        upd(32'h40, 1'b1, 1'b1);
        expect_val(0, 1, "retrained_wt"); step();
        update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_predicted = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        update_valid = 1'b0; rst = 1'b0;
        expect_val(0, 0, "rst_table_wnt"); expect_val(1, 0, "rst_misp");
        expect_val(2, 0, "rst_bc"); expect_val(3, 0, "rst_mc");
        step();
        upd(32'h40, 1'b1, 1'b1);
        expect_val(0, 1, "rst_then_one_taken");
        step();
        repeat (2) step();

        if (q_cyc.size() != 0) begin
            errors += q_cyc.size();
            $display("FAIL leftover: %0d expectations never checked, expected 0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
